// File: rtl/dot_accum_requant.sv
// Accumulates tag-aligned partial dot products into one vector result, then biases, rounds,
// shifts, optionally clamps negatives, saturates and queues results behind a credit-gated FIFO.
module dot_accum_requant #(
  parameter int unsigned IN_W      = 16,
  parameter int unsigned ACC_W     = 32,
  parameter int unsigned OUT_W     = 8,
  parameter int unsigned LAT       = 6,
  parameter int unsigned OUT_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  input  logic [IN_W-1:0]  dot_in,
  input  logic [ACC_W-1:0] bias,
  input  logic [4:0]       shift,
  input  logic             relu_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             err_drop
);

  localparam int unsigned PW = $clog2(OUT_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned RW = ACC_W + 2;

  localparam logic signed [RW-1:0] SatMax = (RW'(1) <<< (OUT_W - 1)) - RW'(1);
  localparam logic signed [RW-1:0] SatMin = -SatMax - RW'(1);

  logic                    in_ready_q;
  logic                    beat;
  logic [LAT-1:0]          tag_v_q, tag_l_q;
  logic                    al_v, al_l;
  logic signed [ACC_W-1:0] acc_q, acc_d, dot_ext;
  logic                    first_q;
  logic                    post_v_q;
  logic signed [ACC_W:0]   post_sum_q, sum_d;
  logic signed [RW-1:0]    rnd_inc, rnd, shifted, relu_v;
  logic [OUT_W-1:0]        res;
  logic [OUT_W-1:0]        mem_q [OUT_DEPTH];
  logic [PW-1:0]           wr_q, rd_q;
  logic [CW-1:0]           cnt_q, cnt_d, infl_q, infl_d;
  logic [CW:0]             occ_d;
  logic                    push, pop;
  logic                    err_q;

  assign in_ready  = in_ready_q;
  assign beat      = in_valid & in_ready_q;
  assign al_v      = tag_v_q[LAT-1];
  assign al_l      = tag_l_q[LAT-1];
  assign push      = post_v_q;
  assign out_valid = (cnt_q != '0);
  assign pop       = out_valid & out_ready;
  assign out_data  = mem_q[rd_q];
  assign err_drop  = err_q;

  always_comb begin
    dot_ext = {{(ACC_W - IN_W){dot_in[IN_W-1]}}, dot_in};
    acc_d   = (first_q ? '0 : acc_q) + dot_ext;
    sum_d   = {acc_d[ACC_W-1], acc_d} + {bias[ACC_W-1], bias};
  end

  // Round half up, arithmetic shift, ReLU, saturate. One spare bit keeps the round add exact.
  always_comb begin
    rnd_inc = (shift != 5'd0) ? (RW'(1) << (shift - 5'd1)) : '0;
    rnd     = {post_sum_q[ACC_W], post_sum_q} + rnd_inc;
    shifted = rnd >>> shift;
    relu_v  = (relu_en && shifted[RW-1]) ? '0 : shifted;
    if (relu_v > SatMax)      res = SatMax[OUT_W-1:0];
    else if (relu_v < SatMin) res = SatMin[OUT_W-1:0];
    else                      res = relu_v[OUT_W-1:0];
  end

  always_comb begin
    cnt_d  = cnt_q + CW'(push) - CW'(pop);
    infl_d = infl_q + CW'(beat & in_last) - CW'(push);
    occ_d  = {1'b0, cnt_d} + {1'b0, infl_d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_v_q <= '0;
      tag_l_q <= '0;
    end else begin
      tag_v_q[0] <= beat;
      tag_l_q[0] <= beat & in_last;
      for (int i = 1; i < int'(LAT); i++) begin
        tag_v_q[i] <= tag_v_q[i-1];
        tag_l_q[i] <= tag_l_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q      <= '0;
      first_q    <= 1'b1;
      post_v_q   <= 1'b0;
      post_sum_q <= '0;
    end else begin
      post_v_q <= al_v & al_l;
      if (al_v) begin
        acc_q   <= acc_d;
        first_q <= al_l;
      end
      if (al_v && al_l) post_sum_q <= sum_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(OUT_DEPTH); i++) mem_q[i] <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
      infl_q     <= '0;
      in_ready_q <= 1'b1;
      err_q      <= 1'b0;
    end else begin
      if (push) begin
        mem_q[wr_q] <= res;
        wr_q        <= wr_q + PW'(1);
      end
      if (pop) rd_q <= rd_q + PW'(1);
      cnt_q  <= cnt_d;
      infl_q <= infl_d;
      // Credits count the just-accepted last, so the FIFO can never overflow.
      in_ready_q <= occ_d < (CW + 1)'(OUT_DEPTH);
      if (in_valid && !in_ready_q) err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dot_accum_requant.sv
// Directed and table-driven bench for dot_accum_requant; models the free-running dot unit
// as a LAT-deep value delay line that outputs junk when no chunk is aligned.
module tb_dot_accum_requant;

  localparam int LAT = 6;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_last, in_ready;
  logic [15:0] dot_in;
  logic [31:0] bias;
  logic [4:0]  shift;
  logic        relu_en;
  logic        out_valid, out_ready;
  logic [7:0]  out_data;
  logic        err_drop;

  dot_accum_requant #(
    .IN_W(16), .ACC_W(32), .OUT_W(8), .LAT(LAT), .OUT_DEPTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .dot_in(dot_in), .bias(bias), .shift(shift), .relu_en(relu_en),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .err_drop(err_drop)
  );

  always #5 clk = ~clk;

  typedef struct {
    int n;
    int ch [4];
    int b;
    int sh;
    bit relu;
    int exp;
  } vec_t;

  vec_t        tbl [9];
  int          total = 0;
  int          bad = 0;
  int          got [$];
  int          expq [$];
  logic [15:0] dl [LAT];
  logic [15:0] cur_chunk;
  bit          rand_ready = 1'b0;

  task automatic check(string name, longint act, longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, wanted %0d", name, act, req);
    end
  endtask

  // One clock: sample handshakes mid-cycle, then advance the dot-unit model after the edge.
  task automatic step();
    bit beat;
    beat = in_valid && in_ready;
    if (out_valid && out_ready) got.push_back(int'($signed(out_data)));
    @(posedge clk);
    #1;
    for (int i = LAT - 1; i > 0; i--) dl[i] = dl[i-1];
    dl[0]  = beat ? cur_chunk : 16'h5a5a;
    dot_in = dl[LAT-1];
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_cycles(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic issue(int val, bit last);
    int k = 0;
    while (!in_ready && k < 200) begin
      step();
      k++;
    end
    if (!in_ready) check("issue_timeout", 0, 1);
    in_valid  = 1'b1;
    in_last   = last;
    cur_chunk = val[15:0];
    step();
    in_valid  = 1'b0;
    in_last   = 1'b0;
  endtask

  task automatic setv(int i, int n, int c0, int c1, int c2, int c3, int b, int sh, bit r,
                      int e);
    tbl[i].n     = n;
    tbl[i].ch[0] = c0;
    tbl[i].ch[1] = c1;
    tbl[i].ch[2] = c2;
    tbl[i].ch[3] = c3;
    tbl[i].b     = b;
    tbl[i].sh    = sh;
    tbl[i].relu  = r;
    tbl[i].exp   = e;
  endtask

  function automatic int model(longint sum, int sh, bit relu);
    longint v = sum;
    longint one = 1;
    if (sh > 0) v = v + (one << (sh - 1));
    v = v >>> sh;
    if (relu && v < 0) v = 0;
    if (v > 127) v = 127;
    if (v < -128) v = -128;
    return int'(v);
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, wanted finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc;
    longint sum;
    int n;
    int val;

    for (int i = 0; i < LAT; i++) dl[i] = 16'h5a5a;
    dot_in    = 16'h5a5a;
    cur_chunk = '0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    bias      = '0;
    shift     = '0;
    relu_en   = 1'b0;
    out_ready = 1'b1;
    rst_n     = 1'b0;
    wait_cycles(3);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_err_drop", err_drop, 0);
    rst_n = 1'b1;
    wait_cycles(2);

    // Issue-to-output latency is LAT+2 cycles.
    issue(100, 1'b1);
    cyc = 1;
    while (!out_valid && cyc < 40) begin
      step();
      cyc++;
    end
    check("latency", cyc, LAT + 2);
    check("latency_data", $signed(out_data), 100);
    wait_cycles(4);
    got.delete();

    setv(0, 1, 100, 0, 0, 0, 0, 0, 0, 100);
    setv(1, 1, 300, 0, 0, 0, 0, 0, 0, 127);
    setv(2, 4, 1000, -200, 50, 7, -57, 3, 0, 100);
    setv(3, 1, -13, 0, 0, 0, 0, 2, 0, -3);
    setv(4, 1, -13, 0, 0, 0, 0, 2, 1, 0);
    setv(5, 1, 6, 0, 0, 0, 0, 2, 0, 2);
    setv(6, 1, -300, 0, 0, 0, 0, 0, 0, -128);
    setv(7, 2, -1000, -1000, 0, 0, 0, 4, 0, -125);
    setv(8, 2, 5, 5, 0, 0, 10, 1, 0, 10);

    for (int i = 0; i < 9; i++) begin
      bias    = tbl[i].b;
      shift   = 5'(tbl[i].sh);
      relu_en = tbl[i].relu;
      got.delete();
      for (int j = 0; j < tbl[i].n; j++) issue(tbl[i].ch[j], j == tbl[i].n - 1);
      wait_cycles(14);
      check($sformatf("tbl%0d_count", i), got.size(), 1);
      check($sformatf("tbl%0d_value", i), (got.size() > 0) ? got[0] : -999, tbl[i].exp);
    end

    // Backpressure: four results fill the credits, a fifth beat is dropped.
    bias = '0; shift = '0; relu_en = 1'b0;
    out_ready = 1'b0;
    got.delete();
    for (int i = 1; i <= 4; i++) issue(i * 10, 1'b1);
    check("bp_in_ready_low", in_ready, 0);
    in_valid = 1'b1; in_last = 1'b1; cur_chunk = 16'd99;
    step();
    in_valid = 1'b0; in_last = 1'b0;
    check("bp_err_drop", err_drop, 1);
    wait_cycles(20);
    check("bp_out_valid", out_valid, 1);
    check("bp_head_hold", $signed(out_data), 10);
    check("bp_none_popped", got.size(), 0);
    check("bp_still_full", in_ready, 0);
    out_ready = 1'b1;
    wait_cycles(10);
    check("bp_drain_count", got.size(), 4);
    for (int i = 0; i < 4; i++)
      check($sformatf("bp_drain%0d", i), (got.size() > i) ? got[i] : -999, (i + 1) * 10);
    check("bp_ready_back", in_ready, 1);
    check("bp_empty", out_valid, 0);

    // Reset after 2 of 4 chunks; stale chunks still appear on dot_in afterwards.
    issue(50, 1'b0);
    issue(60, 1'b0);
    rst_n = 1'b0;
    step();
    check("mid_rst_err_drop", err_drop, 0);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_out_valid", out_valid, 0);
    rst_n = 1'b1;
    got.delete();
    issue(5, 1'b1);
    wait_cycles(14);
    check("mid_rst_count", got.size(), 1);
    check("mid_rst_value", (got.size() > 0) ? got[0] : -999, 5);

    // Random vectors with random out_ready against the reference model.
    bias = 32'd3; shift = 5'd2; relu_en = 1'b0;
    got.delete();
    expq.delete();
    rand_ready = 1'b1;
    for (int v = 0; v < 100; v++) begin
      n   = int'($urandom_range(1, 3));
      sum = 3;
      for (int j = 0; j < n; j++) begin
        val = int'($urandom_range(0, 400)) - 200;
        sum = sum + val;
        issue(val, j == n - 1);
      end
      expq.push_back(model(sum, 2, 1'b0));
      if ($urandom_range(0, 3) == 0) step();
    end
    rand_ready = 1'b0;
    out_ready = 1'b1;
    wait_cycles(30);
    check("rand_count", got.size(), expq.size());
    for (int i = 0; i < expq.size(); i++)
      check($sformatf("rand%0d", i), (got.size() > i) ? got[i] : -999, expq[i]);
    check("rand_err_drop", err_drop, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
